// File: rtl/mac_param_acc.sv
// mac_param_acc: parametrised multiply-accumulate with valid/ready handshakes.
// One frame of frame_len accepted operand pairs yields one accumulated result.
// Signedness, saturation and frame length are captured when a frame starts.
module mac_param_acc #(
    parameter int W     = 8,
    parameter int ACC_W = 2 * W + 8,
    parameter int PIPE  = 2,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     X,
    input  logic [W-1:0]     Y,
    input  logic             is_signed,
    input  logic             sat_en,
    input  logic [LEN_W-1:0] frame_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] UMAX = {ACC_W{1'b1}};

    state_t             state_r;
    state_t             state_nxt_s;
    logic               in_ready_s;
    logic               accept_s;
    logic               frame_start_s;
    logic               consume_s;
    logic [LEN_W-1:0]   len_in_s;
    logic [LEN_W-1:0]   len_r;
    logic [LEN_W-1:0]   cnt_r;
    logic               signed_r;
    logic               sat_r;
    logic               eff_signed_s;
    logic [ACC_W-1:0]   xe_s;
    logic [ACC_W-1:0]   ye_s;
    logic [ACC_W-1:0]   prod_s;
    logic [ACC_W-1:0]   pipe_data_r [PIPE];
    logic [PIPE-1:0]    pipe_vld_r;
    logic [ACC_W-1:0]   acc_r;
    logic [ACC_W-1:0]   acc_nxt_s;
    logic [ACC_W:0]     sum_s;
    logic               ovf_evt_s;
    logic               ovf_r;
    logic               out_valid_r;
    logic               tail_s;

    assign accept_s      = in_valid && in_ready_s;
    assign frame_start_s = accept_s && ((state_r == IDLE) || (state_r == HOLD));
    assign consume_s     = out_valid_r && out_ready;
    assign len_in_s      = (frame_len == {LEN_W{1'b0}}) ? LEN_W'(1) : frame_len;
    assign eff_signed_s  = frame_start_s ? is_signed : signed_r;
    // The last product sits in the final stage; the add uses it next edge.
    assign tail_s        = pipe_vld_r[PIPE-1];

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign acc_out   = acc_r;
    assign overflow  = ovf_r;

    // Operands extended to accumulator width; the low ACC_W bits of the
    // product are exact for both signed and unsigned since 2*W <= ACC_W.
    always_comb begin
        xe_s = eff_signed_s ? {{(ACC_W-W){X[W-1]}}, X} : {{(ACC_W-W){1'b0}}, X};
        ye_s = eff_signed_s ? {{(ACC_W-W){Y[W-1]}}, Y} : {{(ACC_W-W){1'b0}}, Y};
        prod_s = xe_s * ye_s;
    end

    // Accumulator update with overflow detection and optional clamping.
    always_comb begin
        sum_s     = {1'b0, acc_r} + {1'b0, pipe_data_r[PIPE-1]};
        acc_nxt_s = sum_s[ACC_W-1:0];
        ovf_evt_s = 1'b0;
        if (signed_r) begin
            ovf_evt_s = (acc_r[ACC_W-1] == pipe_data_r[PIPE-1][ACC_W-1]) &&
                        (sum_s[ACC_W-1] != acc_r[ACC_W-1]);
            if (ovf_evt_s && sat_r) begin
                acc_nxt_s = acc_r[ACC_W-1] ? SMIN : SMAX;
            end else begin
                acc_nxt_s = sum_s[ACC_W-1:0];
            end
        end else begin
            ovf_evt_s = sum_s[ACC_W];
            if (ovf_evt_s && sat_r) begin
                acc_nxt_s = UMAX;
            end else begin
                acc_nxt_s = sum_s[ACC_W-1:0];
            end
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = (len_in_s == LEN_W'(1)) ? DRAIN : ACC;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACC: begin
                if (accept_s && (cnt_r == (len_r - LEN_W'(1)))) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = ACC;
                end
            end
            DRAIN: begin
                if (pipe_vld_r == {PIPE{1'b0}}) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            HOLD: begin
                if (consume_s && accept_s) begin
                    state_nxt_s = (len_in_s == LEN_W'(1)) ? DRAIN : ACC;
                end else if (consume_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs: ready while collecting, or in HOLD when the result leaves.
    always_comb begin
        in_ready_s = 1'b0;
        if (reset) begin
            in_ready_s = 1'b0;
        end else begin
            case (state_r)
                IDLE:    in_ready_s = 1'b1;
                ACC:     in_ready_s = 1'b1;
                HOLD:    in_ready_s = out_ready;
                default: in_ready_s = 1'b0;
            endcase
        end
    end

    // Multiplier pipeline, frame configuration and operand counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PIPE; i++) begin
                pipe_data_r[i] <= {ACC_W{1'b0}};
                pipe_vld_r[i]  <= 1'b0;
            end
            signed_r <= 1'b0;
            sat_r    <= 1'b0;
            len_r    <= LEN_W'(1);
            cnt_r    <= {LEN_W{1'b0}};
        end else begin
            pipe_data_r[0] <= prod_s;
            pipe_vld_r[0]  <= accept_s;
            for (int i = 1; i < PIPE; i++) begin
                pipe_data_r[i] <= pipe_data_r[i-1];
                pipe_vld_r[i]  <= pipe_vld_r[i-1];
            end
            if (frame_start_s) begin
                signed_r <= is_signed;
                sat_r    <= sat_en;
                len_r    <= len_in_s;
                cnt_r    <= LEN_W'(1);
            end else if (accept_s) begin
                cnt_r <= cnt_r + LEN_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Accumulator, sticky overflow and result-valid registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_r       <= {ACC_W{1'b0}};
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (consume_s) begin
            acc_r       <= {ACC_W{1'b0}};
            ovf_r       <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            if (tail_s) begin
                acc_r <= acc_nxt_s;
                ovf_r <= ovf_r | ovf_evt_s;
            end else begin
                acc_r <= acc_r;
                ovf_r <= ovf_r;
            end
            if ((state_r == DRAIN) && (pipe_vld_r == {PIPE{1'b0}})) begin
                out_valid_r <= 1'b1;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

endmodule

// File: tb/tb_mac_param_acc.sv
// Directed testbench for mac_param_acc (W=8, ACC_W=16, PIPE=2).
module tb_mac_param_acc;

    localparam int W     = 8;
    localparam int ACC_W = 16;
    localparam int PIPE  = 2;
    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     X;
    logic [W-1:0]     Y;
    logic             is_signed;
    logic             sat_en;
    logic [LEN_W-1:0] frame_len;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_out;
    logic             overflow;

    int checks = 0;
    int errors = 0;

    mac_param_acc #(.W(W), .ACC_W(ACC_W), .PIPE(PIPE), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .X(X), .Y(Y), .is_signed(is_signed), .sat_en(sat_en),
        .frame_len(frame_len), .out_valid(out_valid), .out_ready(out_ready),
        .acc_out(acc_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Present one operand pair for a single clock edge.
    task automatic send_op(input logic [W-1:0] x, input logic [W-1:0] y);
        in_valid = 1'b1;
        X = x;
        Y = y;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Wait (bounded) until out_valid is seen high.
    task automatic wait_out(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 50; i++) begin
            if (out_valid === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        X = '0; Y = '0; is_signed = 1'b0; sat_en = 1'b0; frame_len = 8'd1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++;
        if (out_valid !== 1'b0 || acc_out !== 16'd0 || overflow !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: got v=%b acc=%0d ovf=%b want 0/0/0", out_valid, acc_out, overflow);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_unsigned_frame;
        is_signed = 1'b0; sat_en = 1'b0; frame_len = 8'd4; out_ready = 1'b1;
        send_op(8'd1, 8'd1);
        send_op(8'd2, 8'd2);
        send_op(8'd3, 8'd3);
        send_op(8'd4, 8'd4);
        for (int k = 4; k <= 5; k++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL unsigned_early_valid: cycle %0d got %b want 0", k, out_valid); end
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL unsigned_latency: got %b want 1 at cycle 6", out_valid); end
        checks++;
        if (acc_out !== 16'd30 || overflow !== 1'b0) begin
            errors++; $display("FAIL unsigned_acc: got %0d ovf=%b want 30 ovf=0", acc_out, overflow);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL unsigned_single_pulse: got %b want 0", out_valid); end
    endtask

    task automatic test_signed;
        bit to;
        is_signed = 1'b1; sat_en = 1'b0; frame_len = 8'd2; out_ready = 1'b1;
        send_op(8'h80, 8'h80);
        // Mid-frame config changes must not affect this frame.
        is_signed = 1'b0; frame_len = 8'd5;
        send_op(8'h7F, 8'hFF);
        wait_out(to);
        checks++;
        if (to || acc_out !== 16'd16257 || overflow !== 1'b0) begin
            errors++; $display("FAIL signed_sum: got %0d ovf=%b to=%b want 16257 ovf=0", acc_out, overflow, to);
        end
        is_signed = 1'b1; frame_len = 8'd1;
        send_op(8'hFD, 8'h05);
        wait_out(to);
        checks++;
        if (to || acc_out !== 16'hFFF1 || overflow !== 1'b0) begin
            errors++; $display("FAIL signed_neg: got %h ovf=%b to=%b want fff1 ovf=0", acc_out, overflow, to);
        end
    endtask

    task automatic test_saturation;
        bit to;
        bit [3:0] modes;
        logic [15:0] want [4];
        logic [W-1:0] opv [4];
        modes = 4'b0000;
        // mode bit order per entry: {is_signed, sat_en}
        want[0] = 16'd65535; opv[0] = 8'd255;   // unsigned saturate
        want[1] = 16'd64003; opv[1] = 8'd255;   // unsigned wrap: 195075 mod 65536
        want[2] = 16'h7FFF;  opv[2] = 8'h80;    // signed saturate at +max
        want[3] = 16'hC000;  opv[3] = 8'h80;    // signed wrap: 49152
        out_ready = 1'b1; frame_len = 8'd3;
        for (int m = 0; m < 4; m++) begin
            is_signed = (m >= 2);
            sat_en    = (m % 2 == 0);
            for (int j = 0; j < 3; j++) send_op(opv[m], opv[m]);
            wait_out(to);
            checks++;
            if (to || acc_out !== want[m] || overflow !== 1'b1) begin
                errors++; $display("FAIL sat_mode%0d: got %0d ovf=%b to=%b want %0d ovf=1", m, acc_out, overflow, to, want[m]);
            end
        end
        modes = 4'b1111;
    endtask

    task automatic test_backpressure;
        bit to;
        is_signed = 1'b0; sat_en = 1'b0; frame_len = 8'd1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        send_op(8'd3, 8'd4);
        wait_out(to);
        checks++;
        if (to) begin errors++; $display("FAIL bp_timeout: got no out_valid want out_valid"); end
        in_valid = 1'b1; X = 8'd5; Y = 8'd5;
        for (int c = 0; c < 10; c++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || acc_out !== 16'd12 || in_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold: cycle %0d got v=%b acc=%0d rdy=%b want 1/12/0", c, out_valid, acc_out, in_ready);
            end
            @(posedge clk);
        end
        #1;
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_consumed: got %b want 0", out_valid); end
        wait_out(to);
        checks++;
        if (to || acc_out !== 16'd25) begin errors++; $display("FAIL bp_new_frame: got %0d to=%b want 25", acc_out, to); end
    endtask

    task automatic test_bubbles;
        bit to;
        bit [5:0] pat;
        pat = 6'b101001;  // bit i drives cycle i: 1,0,0,1,0,1
        is_signed = 1'b0; sat_en = 1'b0; frame_len = 8'd3; out_ready = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) begin
            in_valid = pat[i]; X = 8'd2; Y = 8'd2;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        wait_out(to);
        checks++;
        if (to || acc_out !== 16'd12) begin errors++; $display("FAIL bubbles: got %0d to=%b want 12", acc_out, to); end
    endtask

    task automatic test_reset_mid;
        bit to;
        is_signed = 1'b0; sat_en = 1'b0; frame_len = 8'd4; out_ready = 1'b1;
        @(posedge clk); #1;
        send_op(8'd3, 8'd3);
        send_op(8'd3, 8'd3);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || acc_out !== 16'd0) begin
            errors++; $display("FAIL midreset_clear: got v=%b acc=%0d want 0/0", out_valid, acc_out);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (acc_out !== 16'd0) begin errors++; $display("FAIL midreset_pipe: got %0d want 0", acc_out); end
        frame_len = 8'd2;
        send_op(8'd1, 8'd1);
        send_op(8'd1, 8'd1);
        wait_out(to);
        checks++;
        if (to || acc_out !== 16'd2) begin errors++; $display("FAIL midreset_next: got %0d to=%b want 2", acc_out, to); end
    endtask

    task automatic test_len_zero;
        bit to;
        is_signed = 1'b0; sat_en = 1'b0; frame_len = 8'd0; out_ready = 1'b1;
        send_op(8'd6, 8'd7);
        wait_out(to);
        checks++;
        if (to || acc_out !== 16'd42) begin errors++; $display("FAIL len_zero: got %0d to=%b want 42", acc_out, to); end
    endtask

    initial begin
        test_reset();
        test_unsigned_frame();
        test_signed();
        test_saturation();
        test_backpressure();
        test_bubbles();
        test_reset_mid();
        test_len_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
